pipe_shift_unit: RTL
====================

Name: pipe_shift_unit

Overview:
- Parametrised, valid/ready pipelined shift/rotate execution unit for the RISC pipeline's EX stage.
- Shift levels are split across STAGES register stages. Supports four modes: SLL, SRL, SRA, ROR.
- Carries a destination tag alongside each result so writeback and forwarding logic can match it.
- Per-stage bubble collapse and pipeline flush (branch mispredict) keep throughput at one op/cycle with no stall.

Parameters:
- WIDTH, 32, datapath width. Power of two, 8..64.
- STAGES, 2, number of register stages, 1..log2(WIDTH).
- TAG_W, 5, width of the tag carried with each op (register index).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  kill all in-flight ops.
- in_valid  in  1  input op valid.
- in_ready  out  1  unit accepts input this cycle.
- in_op  in  2  0=SLL, 1=SRL, 2=SRA, 3=ROR.
- in_amt  in  log2(WIDTH)  shift amount, unsigned.
- in_data  in  WIDTH  operand.
- in_tag  in  TAG_W  opaque tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  WIDTH  shifted result.
- out_tag  out  TAG_W  tag of the result.

Behaviour:
- Reset: while rst=1 on an edge, all stage valid bits, out_valid, out_data and out_tag become 0. in_ready is 0 while rst is high and 1 from the first cycle after reset.
- Levels: L=log2(WIDTH) levels, level k shifts by 2^k. ceil(L/STAGES) levels are assigned per stage, lowest k first; the last stage may hold fewer.
- Output registers: the output registers are the last stage.
- Latency: an op accepted at edge N appears on out_valid/out_data after edge N+STAGES-1, i.e. STAGES edges including the accepting one. This holds when there is no stall.
- Advance rule: stage i loads when stage i is empty, or stage i+1 loads in the same cycle. The last stage advances when out_ready=1 or out_valid=0.
- in_ready: in_ready = (stage0 can load) AND NOT flush AND NOT rst. It is combinational from out_ready and the valid bits; there is no path from in_valid.
- Transfer: a transfer occurs on in_valid&in_ready, and separately on out_valid&out_ready. Ops leave in issue order; no loss, no duplication.
- SLL: zero fill.
- SRL: zero fill.
- SRA: fill with in_data[WIDTH-1].
- ROR: bits leaving the LSB enter at the MSB.
- Shift amounts: in_amt=0 passes data unchanged in every mode. in_amt=WIDTH-1 is the maximum; no amount masking is needed.
- Stall: when out_valid=1 and out_ready=0, out_data, out_tag and all stage contents hold stable. Bubbles upstream still collapse.
- flush=1: all valid bits clear at the edge, so out_valid=0 the following cycle. No input is accepted in the flush cycle. An output transfer in the flush cycle (out_valid&out_ready) still counts as delivered. Data/tag registers may keep stale values.
- Simultaneous flush and rst: rst dominates; the result is identical.
- Mid-operation reset: all in-flight ops are discarded with no output.

Optional Feature:
- Macro: SHIFT_FLAGS_EN.
- When defined, adds outputs out_zero (1 bit) and out_carry (1 bit), pipelined with the data and reset to 0.
- out_zero = (out_data==0).
- out_carry by mode:
  - SLL: last bit shifted out, in_data[WIDTH-amt].
  - SRL/SRA: in_data[amt-1].
  - ROR: out_data[WIDTH-1].
  - amt=0: 0.
- When undefined, the ports and their flops do not exist; all other behaviour is identical.

Test Plan:
All scenarios use WIDTH=32, STAGES=2, out_ready=1 unless stated.
- Basic SLL: SLL 0x0000_0001 amt 31, tag 3 -> out_data 0x8000_0000, out_tag 3, out_valid exactly 2 edges after acceptance. With SHIFT_FLAGS_EN: out_carry 0, out_zero 0.
- Right shifts, back-to-back: SRA 0x8000_0000 amt 4, then SRL 0x8000_0000 amt 4, then SRA 0x7fff_ffff amt 31 -> 0xF800_0000, 0x0800_0000, 0x0000_0000 on consecutive cycles. The third result has out_zero=1 and out_carry=1 when flags are enabled.
- Rotate and zero amount: ROR 0x1234_abcd amt 16 -> 0xabcd_1234; ROR 0xffff_cccc amt 0 -> 0xffff_cccc; SLL 0xabff_aaaa amt 0 -> unchanged.
- Backpressure: out_ready=0 while 4 ops with tags 1..4 are offered -> in_ready drops after 2 are accepted and out_data holds the tag-1 result. Release out_ready -> tags 1,2,3,4 emerge in order, one per cycle, with no loss or duplication.
- Flush: flush with 2 ops in flight and in_valid=1 in the same cycle -> in_ready=0 that cycle, out_valid=0 next cycle. The next op (0xade1_8712 SRL 8) emerges as 0x00ad_e187 at normal latency.
- Reset mid-stream: rst=1 for one cycle with 2 ops in flight -> out_valid, out_data and out_tag are 0 next cycle, no stale result ever appears, and in_ready returns to 1 on the following cycle.

Source files
------------

// File: rtl/pipe_shift_unit.sv
// Pipelined valid/ready shift/rotate unit (SLL, SRL, SRA, ROR) carrying a destination tag.
// Define SHIFT_FLAGS_EN to add the registered out_zero / out_carry result flags.
module pipe_shift_unit #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               in_op,
    input  logic [$clog2(WIDTH)-1:0] in_amt,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [TAG_W-1:0]         out_tag
`ifdef SHIFT_FLAGS_EN
    ,
    output logic                     out_zero,
    output logic                     out_carry
`endif
);

    localparam int L    = $clog2(WIDTH);
    localparam int LPS  = (L + STAGES - 1) / STAGES;
    localparam int MS   = (STAGES > 1) ? STAGES - 1 : 1;
    localparam int LAST = STAGES - 1;

    localparam logic [1:0] OP_SLL = 2'd0;
    localparam logic [1:0] OP_SRL = 2'd1;
    localparam logic [1:0] OP_SRA = 2'd2;

    // Handshake: a transfer happens on an edge where valid and ready are both high;
    // in_ready never depends on in_valid, and out_valid/out_data hold until out_ready.

    logic [STAGES-1:0] v_q;
    logic [WIDTH-1:0]  d_q   [STAGES];
    logic [TAG_W-1:0]  t_q   [STAGES];
    logic [1:0]        op_q  [MS];
    logic [L-1:0]      amt_q [MS];

    logic [STAGES-1:0] load;
    logic [STAGES-1:0] s_v;
    logic [WIDTH-1:0]  s_d   [STAGES];
    logic [WIDTH-1:0]  s_res [STAGES];
    logic [1:0]        s_op  [STAGES];
    logic [L-1:0]      s_amt [STAGES];
    logic [TAG_W-1:0]  s_t   [STAGES];

    // Applies the levels lo..hi-1 owned by one stage; level k shifts by 2^k.
    function automatic logic [WIDTH-1:0] shift_levels(input logic [WIDTH-1:0] d,
                                                      input logic [1:0] op,
                                                      input logic [L-1:0] amt,
                                                      input int lo, input int hi);
        logic [WIDTH-1:0] r;
        r = d;
        for (int k = 0; k < L; k++) begin
            if (k >= lo && k < hi && amt[k]) begin
                case (op)
                    OP_SLL:  r = r << (1 << k);
                    OP_SRL:  r = r >> (1 << k);
                    OP_SRA:  r = $signed(r) >>> (1 << k);
                    default: r = (r >> (1 << k)) | (r << (WIDTH - (1 << k)));
                endcase
            end
        end
        return r;
    endfunction

    always_comb begin
        load       = '0;
        load[LAST] = out_ready || !v_q[LAST];
        for (int i = LAST - 1; i >= 0; i--) begin
            load[i] = !v_q[i] || load[i+1];
        end
    end

    assign in_ready = load[0] && !flush && !rst;

    always_comb begin
        s_v      = '0;
        s_v[0]   = in_valid && in_ready;
        s_d[0]   = in_data;
        s_op[0]  = in_op;
        s_amt[0] = in_amt;
        s_t[0]   = in_tag;
        for (int i = 1; i < STAGES; i++) begin
            s_v[i]   = v_q[i-1];
            s_d[i]   = d_q[i-1];
            s_op[i]  = op_q[i-1];
            s_amt[i] = amt_q[i-1];
            s_t[i]   = t_q[i-1];
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        localparam int LO = g * LPS;
        localparam int HI = ((g + 1) * LPS > L) ? L : (g + 1) * LPS;
        assign s_res[g] = shift_levels(s_d[g], s_op[g], s_amt[g], LO, HI);
    end

    // Data registers only capture real ops, so bubbles never disturb held contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                d_q[i] <= '0;
                t_q[i] <= '0;
            end
            for (int i = 0; i < MS; i++) begin
                op_q[i]  <= '0;
                amt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (flush) begin
                    v_q[i] <= 1'b0;
                end else if (load[i]) begin
                    v_q[i] <= s_v[i];
                end
                if (load[i] && s_v[i]) begin
                    d_q[i] <= s_res[i];
                    t_q[i] <= s_t[i];
                end
            end
            for (int i = 0; i < STAGES - 1; i++) begin
                if (load[i] && s_v[i]) begin
                    op_q[i]  <= s_op[i];
                    amt_q[i] <= s_amt[i];
                end
            end
        end
    end

    assign out_valid = v_q[LAST];
    assign out_data  = d_q[LAST];
    assign out_tag   = t_q[LAST];

`ifdef SHIFT_FLAGS_EN
    localparam logic [L-1:0] ONE = 1;

    logic [STAGES-1:0] c_q;
    logic [STAGES-1:0] s_c;
    logic              z_q;
    logic [L-1:0]      sll_idx;
    logic [L-1:0]      srl_idx;
    logic              in_carry;

    // For ROR the bit landing in the MSB is in_data[amt-1], same as the right shifts.
    always_comb begin
        sll_idx  = ~in_amt + ONE;
        srl_idx  = in_amt - ONE;
        in_carry = 1'b0;
        if (in_amt != '0) begin
            in_carry = (in_op == OP_SLL) ? in_data[sll_idx] : in_data[srl_idx];
        end
        s_c    = '0;
        s_c[0] = in_carry;
        for (int i = 1; i < STAGES; i++) begin
            s_c[i] = c_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            c_q <= '0;
            z_q <= 1'b0;
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (load[i] && s_v[i]) begin
                    c_q[i] <= s_c[i];
                end
            end
            if (load[LAST] && s_v[LAST]) begin
                z_q <= (s_res[LAST] == '0);
            end
        end
    end

    assign out_zero  = z_q;
    assign out_carry = c_q[LAST];
`endif

endmodule
